// File: rtl/mult_fu_pipelined.sv
// Pipelined integer multiply unit: one partial-product chunk per stage, with the result held
// in the last stage until a CDB grant. Ops are squashed on a branch mispredict.
module mult_fu_pipelined #(
  parameter int XLEN    = 32,
  parameter int STAGES  = 4,
  parameter int PREG_W  = 6,
  parameter int BMASK_W = 4,
  localparam int OCC_W  = $clog2(STAGES + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_func,
  input  logic [XLEN-1:0]    in_rs1,
  input  logic [XLEN-1:0]    in_rs2,
  input  logic [PREG_W-1:0]  in_tag,
  input  logic [BMASK_W-1:0] in_bmask,
  input  logic               cdb_gnt,
  output logic               cdb_req,
  output logic [PREG_W-1:0]  out_tag,
  output logic [XLEN-1:0]    out_result,
  output logic [BMASK_W-1:0] out_bmask,
  output logic [OCC_W-1:0]   occupancy,
  input  logic [BMASK_W-1:0] b_mm_resolve,
  input  logic               b_mm_mispred
);

  localparam int PW = 2 * XLEN;
  localparam int C  = PW / STAGES;

  typedef enum logic [1:0] {FN_MUL, FN_MULH, FN_MULHSU, FN_MULHU} func_t;

  typedef struct packed {
    logic               valid;
    func_t              func;
    logic [PREG_W-1:0]  tag;
    logic [BMASK_W-1:0] bmask;
    logic [PW-1:0]      a;
    logic [PW-1:0]      b;
    logic [PW-1:0]      acc;
  } stage_t;

  stage_t stg_q [STAGES];
  stage_t stg_d [STAGES];

  logic [STAGES-1:0]  live;
  logic [STAGES-1:0]  load;
  logic [BMASK_W-1:0] clr_mask;
  logic               a_sgn, b_sgn, issue_kill, ld_acc;
  logic [PW-1:0]      a_x, b_x, chunk0, chunk;
  logic [OCC_W-1:0]   occ_d;

  // A stage squashed this cycle is treated as empty, so it neither requests nor blocks.
  always_comb begin
    for (int i = 0; i < STAGES; i++)
      live[i] = stg_q[i].valid && !(b_mm_mispred && (|(stg_q[i].bmask & b_mm_resolve)));
  end

  // A stage can load when it, or any stage downstream of it, is empty, or when the last stage is granted.
  always_comb begin
    ld_acc = !live[STAGES-1] || cdb_gnt;
    load   = '0;
    load[STAGES-1] = ld_acc;
    for (int i = STAGES - 2; i >= 0; i--) begin
      ld_acc  = ld_acc || !live[i];
      load[i] = ld_acc;
    end
  end

  assign in_ready = load[0];

  always_comb begin
    clr_mask   = b_mm_mispred ? '0 : b_mm_resolve;
    issue_kill = b_mm_mispred && (|(in_bmask & b_mm_resolve));
    a_sgn      = (in_func != 2'b11);
    b_sgn      = !in_func[1];
    a_x        = {{XLEN{a_sgn & in_rs1[XLEN-1]}}, in_rs1};
    b_x        = {{XLEN{b_sgn & in_rs2[XLEN-1]}}, in_rs2};
    chunk0     = {{(PW-C){1'b0}}, b_x[C-1:0]};
    chunk      = '0;
    occ_d      = '0;

    stg_d[0]       = stg_q[0];
    stg_d[0].valid = live[0];
    stg_d[0].bmask = stg_q[0].bmask & ~clr_mask;
    if (load[0]) begin
      stg_d[0].valid = in_valid && !issue_kill;
      stg_d[0].func  = func_t'(in_func);
      stg_d[0].tag   = in_tag;
      stg_d[0].bmask = in_bmask & ~clr_mask;
      stg_d[0].a     = a_x;
      stg_d[0].b     = b_x;
      stg_d[0].acc   = a_x * chunk0;
    end

    for (int i = 1; i < STAGES; i++) begin
      stg_d[i]       = stg_q[i];
      stg_d[i].valid = live[i];
      stg_d[i].bmask = stg_q[i].bmask & ~clr_mask;
      if (load[i]) begin
        chunk          = '0;
        chunk[C-1:0]   = stg_q[i-1].b[i*C +: C];
        stg_d[i]       = stg_q[i-1];
        stg_d[i].valid = live[i-1];
        stg_d[i].bmask = stg_q[i-1].bmask & ~clr_mask;
        stg_d[i].acc   = stg_q[i-1].acc + ((stg_q[i-1].a * chunk) << (i * C));
      end
    end

    for (int i = 0; i < STAGES; i++)
      occ_d = occ_d + OCC_W'(stg_d[i].valid);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) stg_q[i] <= '0;
      occupancy <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) stg_q[i] <= stg_d[i];
      occupancy <= occ_d;
    end
  end

  assign cdb_req    = live[STAGES-1];
  assign out_tag    = cdb_req ? stg_q[STAGES-1].tag : '0;
  assign out_bmask  = cdb_req ? stg_q[STAGES-1].bmask : '0;
  assign out_result = !cdb_req ? '0 :
                      (stg_q[STAGES-1].func == FN_MUL) ? stg_q[STAGES-1].acc[XLEN-1:0]
                                                       : stg_q[STAGES-1].acc[PW-1:XLEN];

endmodule
